// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: buffer entry layout, tag-pipe entry and PC helpers.
// Entries travel as packed structs so the buffer width follows the PC and instruction widths.
package fetch_unit_pkg;

   localparam int INST_W = 32;
   localparam int PC_W   = 32;
   localparam logic [PC_W-1:0] PC_INC = 32'd4;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   typedef struct packed {
      logic            vld;
      logic [PC_W-1:0] pc;
   } fetch_tag_t;

   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// Show-ahead synchronous FIFO of {pc, inst}; head is visible while not empty and reads as 0 when empty.
// Flush drops every entry in one cycle and takes priority over push and pop.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         flush_in,
   input  logic         push_in,
   input  fetch_entry_t push_dat_in,
   input  logic         pop_in,
   output fetch_entry_t head_out,
   output logic         empty_out,
   output logic [CW-1:0] count_out
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full, push_ok, pop_ok;

   assign empty_out = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));
   assign count_out = cnt_q;
   assign head_out  = empty_out ? '0 : mem_q[rd_ptr_q];

   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign pop_ok  = pop_in && !empty_out;
   assign push_ok = push_in && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_in) begin
         rd_ptr_d = wr_ptr_q;
         cnt_d    = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push_ok && !flush_in) begin
         mem_q[wr_ptr_q] <= push_dat_in;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues BRAM word reads, tracks them in a tag pipe and buffers responses.
// Credits (in-flight + buffered) cap requests so every BRAM response always finds a free buffer slot.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEM_LATENCY = 2,
   parameter int          BUF_DEPTH   = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        redirect_valid_in,
   input  logic [31:0] redirect_pc_in,
   output logic        imem_en_out,
   output logic [31:0] imem_addr_out,
   input  logic [31:0] imem_data_in,
   input  logic        ready_in,
   output logic        valid_out,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
   localparam int CRD_W = CNT_W + 8;

   logic [PC_W-1:0] pc_q, pc_d;
   fetch_tag_t      tag_q [MEM_LATENCY];
   fetch_tag_t      tag_tail;

   logic [CNT_W-1:0] occ;
   logic [CRD_W-1:0] inflight, credits_used;
   logic             req, push, pop, buf_empty;
   fetch_entry_t     push_dat, head;

   assign tag_tail = tag_q[MEM_LATENCY-1];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
         inflight = inflight + CRD_W'(tag_q[i].vld);
      end
   end

   assign credits_used = inflight + CRD_W'(occ);
   assign req          = !rst_in && !redirect_valid_in && (credits_used < CRD_W'(BUF_DEPTH));

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid_in) begin
         pc_d = word_align(redirect_pc_in);
      end else if (req) begin
         pc_d = pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < MEM_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         pc_q <= pc_d;
         // A redirect kills everything still travelling through the BRAM.
         if (redirect_valid_in) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
               tag_q[i] <= '0;
            end
         end else begin
            tag_q[0] <= '{vld: req, pc: pc_q};
            for (int i = 1; i < MEM_LATENCY; i++) begin
               tag_q[i] <= tag_q[i-1];
            end
         end
      end
   end

   assign push          = tag_tail.vld && !redirect_valid_in;
   assign push_dat.pc   = tag_tail.pc;
   assign push_dat.inst = imem_data_in;

   assign valid_out       = !buf_empty && !redirect_valid_in && !rst_in;
   assign pop             = valid_out && ready_in;
   assign instruction_out = head.inst;
   assign pc_out          = head.pc;

   assign imem_en_out   = req;
   assign imem_addr_out = pc_q;

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .flush_in    (redirect_valid_in),
      .push_in     (push),
      .push_dat_in (push_dat),
      .pop_in      (pop),
      .head_out    (head),
      .empty_out   (buf_empty),
      .count_out   (occ)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench: a BRAM model returns addr/4, the expected {pc, inst} stream is queued on each
// reset/redirect and popped on every output handshake.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          L        = 2;
   localparam int          D        = 4;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        redirect_valid_in;
   logic [31:0] redirect_pc_in;
   logic        imem_en_out;
   logic [31:0] imem_addr_out;
   logic [31:0] imem_data_in;
   logic        ready_in;
   logic        valid_out;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;

   always #5 clk_in = ~clk_in;

   fetch_unit #(
      .RESET_PC    (RESET_PC),
      .MEM_LATENCY (L),
      .BUF_DEPTH   (D)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .redirect_valid_in (redirect_valid_in),
      .redirect_pc_in    (redirect_pc_in),
      .imem_en_out       (imem_en_out),
      .imem_addr_out     (imem_addr_out),
      .imem_data_in      (imem_data_in),
      .ready_in          (ready_in),
      .valid_out         (valid_out),
      .instruction_out   (instruction_out),
      .pc_out            (pc_out)
   );

   // BRAM model: fixed-latency read, data word at byte address a is a/4.
   logic [L-1:0] mp_vld = '0;
   logic [31:0]  mp_addr [L];

   always @(posedge clk_in) begin
      mp_vld[0]  <= imem_en_out;
      mp_addr[0] <= imem_addr_out;
      for (int i = 1; i < L; i++) begin
         mp_vld[i]  <= mp_vld[i-1];
         mp_addr[i] <= mp_addr[i-1];
      end
   end

   assign imem_data_in = mp_vld[L-1] ? (mp_addr[L-1] >> 2) : 32'hDEAD_BEEF;

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        mon_e;
   logic [31:0] next_pc;
   int          os = 0;

   task automatic extend(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.pc    = next_pc;
         e.inst  = next_pc >> 2;
         exp_q.push_back(e);
         next_pc = next_pc + 32'd4;
      end
   endtask

   task automatic restart(input logic [31:0] pc);
      exp_q.delete();
      os      = 0;
      next_pc = pc;
      extend(16);
   endtask

   always @(negedge clk_in) begin
      if (rst_in || redirect_valid_in) begin
         chk("flush_valid", 32'(valid_out), 32'd0);
         chk("flush_en", 32'(imem_en_out), 32'd0);
         restart(rst_in ? RESET_PC : {redirect_pc_in[31:2], 2'b00});
      end else begin
         if (exp_q.size() < 8) extend(16);
         if (valid_out && ready_in) begin
            mon_e = exp_q.pop_front();
            chk("pc", pc_out, mon_e.pc);
            chk("inst", instruction_out, mon_e.inst);
         end
         os = os + (imem_en_out ? 1 : 0) - ((valid_out && ready_in) ? 1 : 0);
         chk("occ_bound", 32'(os <= D), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic measure_latency(input string tag);
      int first;
      first = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_in);
         if (valid_out) begin
            first = c;
            break;
         end
      end
      chk(tag, 32'(first), 32'(L + 1));
   endtask

   initial begin
      rst_in            = 1'b1;
      redirect_valid_in = 1'b0;
      redirect_pc_in    = '0;
      ready_in          = 1'b1;

      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_en", 32'(imem_en_out), 32'd0);
      chk("rst_addr", imem_addr_out, RESET_PC);
      chk("rst_inst", instruction_out, 32'd0);
      chk("rst_pc", pc_out, 32'd0);

      tick();
      rst_in = 1'b0;
      measure_latency("first_latency");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         chk("stream_valid", 32'(valid_out), 32'd1);
      end

      // Stall downstream until the credit limit stops fetch.
      tick();
      ready_in = 1'b0;
      repeat (20) tick();
      @(negedge clk_in);
      #1;
      chk("bp_buffered", 32'(os), 32'(D));
      chk("bp_en", 32'(imem_en_out), 32'd0);
      chk("bp_valid", 32'(valid_out), 32'd1);
      tick();
      ready_in = 1'b1;
      repeat (10) tick();

      // Redirect with words both buffered and in flight.
      ready_in = 1'b0;
      repeat (2) tick();
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h0000_0100;
      tick();
      redirect_valid_in = 1'b0;
      ready_in          = 1'b1;
      @(negedge clk_in);
      chk("rd100_en", 32'(imem_en_out), 32'd1);
      chk("rd100_addr", imem_addr_out, 32'h0000_0100);
      repeat (8) tick();

      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h0000_0203;
      tick();
      redirect_valid_in = 1'b0;
      @(negedge clk_in);
      chk("rd203_addr", imem_addr_out, 32'h0000_0200);
      repeat (6) tick();

      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'h0000_0040;
      tick();
      redirect_pc_in    = 32'h0000_0080;
      tick();
      redirect_valid_in = 1'b0;
      @(negedge clk_in);
      chk("rd_b2b_addr", imem_addr_out, 32'h0000_0080);
      repeat (8) tick();

      // PC wrap through the top of the address space.
      redirect_valid_in = 1'b1;
      redirect_pc_in    = 32'hFFFF_FFF8;
      tick();
      redirect_valid_in = 1'b0;
      @(negedge clk_in);
      chk("wrap_addr", imem_addr_out, 32'hFFFF_FFF8);
      repeat (10) tick();

      for (int i = 0; i < 1000; i++) begin
         ready_in = 1'($urandom_range(0, 1));
         tick();
      end

      // Reset while responses are outstanding.
      ready_in = 1'b1;
      tick();
      rst_in = 1'b1;
      repeat (2) tick();
      rst_in = 1'b0;
      measure_latency("post_rst_latency");
      repeat (12) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
